gf180mcu_ocd_io__pwr_seq: RTL and testbench
===========================================

// Module: gf180mcu_ocd_io__pwr_seq
// PURPOSE
//   Parametrised supply-rail sequencer for the pad ring's VDD/DVDD power cells.
//   Enables NCH rail switches one at a time in ascending order; each rail must
//   show debounced power-good before the next one is enabled. Rails shut down in
//   reverse order. Any rail that fails to come up, or drops while on, forces an
//   immediate all-off fault. Sits between the always-on control logic and the
//   rail-switch enables / comparator outputs of the IO power cells.
// PARAMETERS
//   NCH    4    number of supply rails sequenced (>=2)
//   CNT_W  8    width of the ramp-delay counter and the timeout counter
//   DEB    3    consecutive equal synchronised samples needed to change pg_deb[i] (>=1)
//   TMO    255  max cycles spent in UP_CHK waiting for power-good (< 2**CNT_W)
// PORTS
//   CLK       in   1                clock
//   RST       in   1                reset, synchronous, active-high
//   PWR_REQ   in   1                level request: 1 = power up, 0 = power down
//   RAMP_DLY  in   CNT_W            settle delay after each EN change, sampled per step
//   PG_RAW    in   NCH              asynchronous power-good from the rail comparators
//   EN        out  NCH              rail-switch enables, registered
//   PG_OK     out  1                all rails up and stable (state ON)
//   BUSY      out  1                in UP_DLY, UP_CHK or DN_DLY
//   FAULT     out  1                sticky fault flag
//   FAULT_CH  out  $clog2(NCH)      index of the faulting rail, held while FAULT=1
// BEHAVIOUR
//   Reset: one clock only; RST is synchronous and active-high. While RST=1 at an edge:
//     - state=OFF, EN=0, PG_OK=0, BUSY=0, FAULT=0, FAULT_CH=0
//     - sync flops, debouncers and counters are cleared
//   RST asserted mid-sequence clears all state at the next edge; no orderly shutdown.
//   PG path: 2-flop synchroniser per bit, then a per-channel debouncer.
//     - pg_deb[i] toggles only after DEB consecutive synchronised samples of the new value.
//     - Detection latency from PG_RAW edge to pg_deb = 2+DEB cycles.
//   idx: channel pointer, width $clog2(NCH). FSM states (registered):
//     OFF:    EN=0. PWR_REQ=1 -> UP_DLY with idx=0, EN[0] set at the same edge,
//             cnt<=RAMP_DLY.
//     UP_DLY: cnt decrements each cycle (RAMP_DLY+1 cycles total, so 0 is legal).
//             At cnt==0 -> UP_CHK with tmo<=0.
//     UP_CHK: if pg_deb[idx]=1:
//               - idx==NCH-1 -> ON
//               - otherwise idx++, set EN[idx+1], cnt<=RAMP_DLY, go to UP_DLY
//             tmo increments each cycle; tmo==TMO with pg_deb[idx]=0 -> FAULT,
//             FAULT_CH<=idx.
//     ON:     PG_OK=1. Any pg_deb[i]=0 -> FAULT, FAULT_CH = lowest such i
//             (priority over PWR_REQ=0 in the same cycle).
//             PWR_REQ=0 -> DN_DLY: idx=NCH-1, clear EN[NCH-1], PG_OK=0 at the same edge.
//     DN_DLY: RAMP_DLY+1 cycles, then:
//               - idx==0 -> OFF
//               - otherwise idx--, clear EN[idx-1], reload cnt
//             PG is not checked while in DN_DLY.
//     FAULT:  EN=0 at the entry edge (all rails at once), FAULT=1, PG_OK=0, BUSY=0.
//             Exit only after PWR_REQ=0 is sampled -> OFF, FAULT clears.
//   PWR_REQ=0 during UP_DLY/UP_CHK -> DN_DLY from the current idx: clear EN[idx],
//   then descend. A fault check in UP_CHK at the same edge takes priority.
//   PWR_REQ=1 during DN_DLY is ignored until OFF is reached.
//   EN is always a thermometer code (EN[i]=1 implies EN[j]=1 for all j<i).
//   The verification bench asserts this every cycle.
//   Counters saturate; no wrap-around.
// TESTING
//   1. NCH=4, RAMP_DLY=4, PG_RAW=EN delayed 3 cycles, PWR_REQ 0->1
//      -> EN goes 0001,0011,0111,1111 in order; PG_OK=1; FAULT=0.
//   2. From ON, PWR_REQ 1->0 -> EN goes 0111,0011,0001,0000, 5 cycles apart;
//      PG_OK falls on the first edge; BUSY=1 until OFF.
//   3. PG_RAW[2] held 0 -> exactly TMO cycles after UP_CHK entry for idx=2:
//      FAULT=1, FAULT_CH=2, EN=0000.
//   4. In ON, PG_RAW[1] low for DEB+1 cycles (survives sync) -> FAULT=1,
//      FAULT_CH=1, EN=0000. A low pulse of DEB-1 cycles -> no fault.
//   5. PWR_REQ drops in UP_DLY with idx=1 -> EN goes 0001 then 0000, no fault;
//      re-request after OFF restarts from EN=0001.
//   6. RST=1 for one edge while in ON -> next cycle EN=0, PG_OK=0, FAULT=0,
//      state OFF; PWR_REQ still 1 -> EN=0001 on the following edge.

Source files
------------

// File: rtl/gf180mcu_ocd_io__pwr_seq.sv
// Purpose: ordered power-up / reverse power-down sequencer for the pad-ring supply rails, with debounced power-good and all-off fault.
// Latency: pg_raw edge reaches pg_deb after 2+DEB cycles; each rail step waits ramp_dly+1 cycles, then for power-good.
// Backpressure: none; pwr_req is a level request, and a drop is honoured at the next edge outside FAULT.
module gf180mcu_ocd_io__pwr_seq #(
   parameter int NCH   = 4,
   parameter int CNT_W = 8,
   parameter int DEB   = 3,
   parameter int TMO   = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    pwr_req,
   input  logic [CNT_W-1:0]        ramp_dly,
   input  logic [NCH-1:0]          pg_raw,
   output logic [NCH-1:0]          en,
   output logic                    pg_ok,
   output logic                    busy,
   output logic                    fault,
   output logic [$clog2(NCH)-1:0]  fault_ch
);

   localparam int IDX_W = $clog2(NCH);
   localparam int DW    = $clog2(DEB + 1);

   typedef enum logic [2:0] {
      S_OFF    = 3'd0,
      S_UP_DLY = 3'd1,
      S_UP_CHK = 3'd2,
      S_ON     = 3'd3,
      S_DN_DLY = 3'd4,
      S_FLT    = 3'd5
   } state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [CNT_W-1:0]   tmo, tmo_nxt;
   logic [NCH-1:0]     en_nxt;
   logic [IDX_W-1:0]   fch_nxt;
   logic [IDX_W-1:0]   low_bad;
   logic               tmo_hit;

   logic [NCH-1:0]     sync1, sync2, pg_deb;
   logic [DW-1:0]      dcnt [NCH];

   // Two-flop synchroniser, then a per-rail debouncer that flips pg_deb only after DEB equal samples of the new value
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= '0;
         sync2  <= '0;
         pg_deb <= '0;
         for (int i = 0; i < NCH; i++) dcnt[i] <= '0;
      end else begin
         sync1 <= pg_raw;
         sync2 <= sync1;
         for (int i = 0; i < NCH; i++) begin
            if (sync2[i] == pg_deb[i]) begin
               dcnt[i] <= '0;
            end else if (dcnt[i] == DW'(DEB - 1)) begin
               pg_deb[i] <= sync2[i];
               dcnt[i]   <= '0;
            end else begin
               dcnt[i] <= dcnt[i] + 1'b1;
            end
         end
      end
   end

   // Lowest rail whose debounced power-good has dropped, reported as the fault channel
   always_comb begin
      low_bad = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (!pg_deb[i]) low_bad = IDX_W'(i);
      end
   end

   // Timeout fires on the TMO-th UP_CHK cycle without power-good
   assign tmo_hit = (tmo == CNT_W'(TMO - 1));

   // State register: FSM state, channel pointer, counters, registered enables and fault channel
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_OFF;
         idx      <= '0;
         cnt      <= '0;
         tmo      <= '0;
         en       <= '0;
         fault_ch <= '0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         cnt      <= cnt_nxt;
         tmo      <= tmo_nxt;
         en       <= en_nxt;
         fault_ch <= fch_nxt;
      end
   end

   // Next-state logic; fault checks win over a dropped request, which wins over advancing
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      tmo_nxt   = tmo;
      en_nxt    = en;
      fch_nxt   = fault_ch;
      case (state)
         S_OFF: begin
            en_nxt = '0;
            if (pwr_req) begin
               state_nxt = S_UP_DLY;
               idx_nxt   = '0;
               en_nxt    = NCH'(1);
               cnt_nxt   = ramp_dly;
            end
         end
         S_UP_DLY: begin
            if (!pwr_req) begin
               state_nxt   = S_DN_DLY;
               en_nxt[idx] = 1'b0;
               cnt_nxt     = ramp_dly;
            end else if (cnt == '0) begin
               state_nxt = S_UP_CHK;
               tmo_nxt   = '0;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         S_UP_CHK: begin
            if (!pg_deb[idx] && tmo_hit) begin
               state_nxt = S_FLT;
               en_nxt    = '0;
               fch_nxt   = idx;
            end else if (!pwr_req) begin
               state_nxt   = S_DN_DLY;
               en_nxt[idx] = 1'b0;
               cnt_nxt     = ramp_dly;
            end else if (pg_deb[idx]) begin
               if (idx == IDX_W'(NCH - 1)) begin
                  state_nxt = S_ON;
               end else begin
                  state_nxt       = S_UP_DLY;
                  idx_nxt         = idx + 1'b1;
                  en_nxt[idx_nxt] = 1'b1;
                  cnt_nxt         = ramp_dly;
               end
            end else begin
               tmo_nxt = (tmo == '1) ? tmo : tmo + 1'b1;
            end
         end
         S_ON: begin
            if (!(&pg_deb)) begin
               state_nxt = S_FLT;
               en_nxt    = '0;
               fch_nxt   = low_bad;
            end else if (!pwr_req) begin
               state_nxt       = S_DN_DLY;
               idx_nxt         = IDX_W'(NCH - 1);
               en_nxt[NCH-1]   = 1'b0;
               cnt_nxt         = ramp_dly;
            end
         end
         S_DN_DLY: begin
            if (cnt == '0) begin
               if (idx == '0) begin
                  state_nxt = S_OFF;
               end else begin
                  idx_nxt         = idx - 1'b1;
                  en_nxt[idx_nxt] = 1'b0;
                  cnt_nxt         = ramp_dly;
               end
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         S_FLT: begin
            en_nxt = '0;
            if (!pwr_req) begin
               state_nxt = S_OFF;
               fch_nxt   = '0;
            end
         end
         default: begin
            state_nxt = S_OFF;
            en_nxt    = '0;
         end
      endcase
   end

   // Status outputs decoded from the registered state
   always_comb begin
      pg_ok = (state == S_ON);
      busy  = (state == S_UP_DLY) || (state == S_UP_CHK) || (state == S_DN_DLY);
      fault = (state == S_FLT);
   end

endmodule

// File: tb/tb_gf180mcu_ocd_io__pwr_seq.sv
module tb_gf180mcu_ocd_io__pwr_seq;

   localparam int NCH   = 4;
   localparam int CNT_W = 8;
   localparam int DEB   = 3;
   localparam int TMO   = 255;

   logic             clk = 1'b0;
   logic             rst;
   logic             pwr_req;
   logic [CNT_W-1:0] ramp_dly;
   logic [NCH-1:0]   pg_raw;
   logic [NCH-1:0]   en;
   logic             pg_ok;
   logic             busy;
   logic             fault;
   logic [1:0]       fault_ch;

   int vectors     = 0;
   int miscompares = 0;
   int ecount      = 0;

   // rail model: pg_raw follows en three cycles late, with per-rail kill mask
   logic [NCH-1:0] d1, d2, d3, kill;

   gf180mcu_ocd_io__pwr_seq #(
      .NCH(NCH), .CNT_W(CNT_W), .DEB(DEB), .TMO(TMO)
   ) dut (
      .clk(clk), .rst(rst), .pwr_req(pwr_req), .ramp_dly(ramp_dly), .pg_raw(pg_raw),
      .en(en), .pg_ok(pg_ok), .busy(busy), .fault(fault), .fault_ch(fault_ch)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, ecount, obs, exp);
      end
   endtask

   task automatic tick();
      logic [NCH-1:0] t;
      @(posedge clk);
      #1;
      ecount++;
      pg_raw = d3 & ~kill;
      d3 = d2;
      d2 = d1;
      d1 = en;
      t  = en + 1'b1;
      chk("thermometer", 32'(t & en), 32'h0);
   endtask

   task automatic goto(input int n);
      while (ecount < n) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1; pwr_req = 1'b0; kill = '0;
      d1 = '0; d2 = '0; d3 = '0;
      tick();
      rst = 1'b0;
      ecount = 0;
   endtask

   initial begin
      rst = 1'b1; pwr_req = 1'b0; ramp_dly = 8'd4; pg_raw = '0;
      kill = '0; d1 = '0; d2 = '0; d3 = '0;

      // reset state
      do_reset();
      chk("rst_en", 32'(en), 32'h0);
      chk("rst_pg_ok", 32'(pg_ok), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);
      chk("rst_fault_ch", 32'(fault_ch), 32'h0);

      // power-up: one rail every 9 edges, ON at edge 37
      pwr_req = 1'b1;
      goto(1);  chk("up_en0", 32'(en), 32'h1); chk("up_busy", 32'(busy), 32'h1);
      goto(9);  chk("up_en0_hold", 32'(en), 32'h1);
      goto(10); chk("up_en1", 32'(en), 32'h3);
      goto(19); chk("up_en2", 32'(en), 32'h7);
      goto(28); chk("up_en3", 32'(en), 32'hf);
      goto(36); chk("up_pgok_pre", 32'(pg_ok), 32'h0); chk("up_busy_pre", 32'(busy), 32'h1);
      goto(37); chk("up_pgok", 32'(pg_ok), 32'h1); chk("up_busy_on", 32'(busy), 32'h0);
      chk("up_fault", 32'(fault), 32'h0);

      // power-down: reverse order, 5 edges apart
      goto(40); pwr_req = 1'b0;
      goto(41); chk("dn_en3", 32'(en), 32'h7); chk("dn_pgok", 32'(pg_ok), 32'h0);
      chk("dn_busy", 32'(busy), 32'h1);
      goto(45); chk("dn_en3_hold", 32'(en), 32'h7);
      goto(46); chk("dn_en2", 32'(en), 32'h3);
      goto(51); chk("dn_en1", 32'(en), 32'h1);
      goto(56); chk("dn_en0", 32'(en), 32'h0); chk("dn_busy_last", 32'(busy), 32'h1);
      goto(60); chk("dn_busy_end", 32'(busy), 32'h1);
      goto(61); chk("dn_off_busy", 32'(busy), 32'h0); chk("dn_fault", 32'(fault), 32'h0);

      // glitch shorter than the debounce window, then a real drop on rail 1
      do_reset(); pwr_req = 1'b1;
      goto(37); chk("g_on", 32'(pg_ok), 32'h1);
      goto(40); kill = 4'b0010;
      goto(42); kill = '0;
      goto(55); chk("g_short_fault", 32'(fault), 32'h0); chk("g_short_pgok", 32'(pg_ok), 32'h1);
      goto(60); kill = 4'b0010;
      goto(64); kill = '0;
      goto(66); chk("g_pre_fault", 32'(fault), 32'h0); chk("g_pre_en", 32'(en), 32'hf);
      goto(67); chk("g_fault", 32'(fault), 32'h1); chk("g_fault_ch", 32'(fault_ch), 32'h1);
      chk("g_en", 32'(en), 32'h0); chk("g_pgok", 32'(pg_ok), 32'h0); chk("g_busy", 32'(busy), 32'h0);
      goto(70); chk("g_sticky", 32'(fault), 32'h1);
      pwr_req = 1'b0;
      goto(71); chk("g_clear", 32'(fault), 32'h0); chk("g_clear_en", 32'(en), 32'h0);

      // rail 2 never good: timeout TMO edges after UP_CHK entry (edge 24)
      do_reset(); kill = 4'b0100; pwr_req = 1'b1;
      goto(19);  chk("t_en2", 32'(en), 32'h7);
      goto(278); chk("t_pre_fault", 32'(fault), 32'h0); chk("t_pre_busy", 32'(busy), 32'h1);
      chk("t_pre_en", 32'(en), 32'h7);
      goto(279); chk("t_fault", 32'(fault), 32'h1); chk("t_fault_ch", 32'(fault_ch), 32'h2);
      chk("t_en", 32'(en), 32'h0);

      // abort during UP_DLY with idx=1, re-request while descending is ignored
      do_reset(); pwr_req = 1'b1;
      goto(10); chk("a_en1", 32'(en), 32'h3);
      goto(12); pwr_req = 1'b0;
      goto(13); chk("a_en_drop", 32'(en), 32'h1); chk("a_busy", 32'(busy), 32'h1);
      chk("a_fault", 32'(fault), 32'h0);
      goto(17); chk("a_en_hold", 32'(en), 32'h1);
      goto(18); chk("a_en_off", 32'(en), 32'h0);
      goto(20); pwr_req = 1'b1;
      goto(22); chk("a_busy_dn", 32'(busy), 32'h1); chk("a_en_dn", 32'(en), 32'h0);
      goto(23); chk("a_off_busy", 32'(busy), 32'h0); chk("a_off_en", 32'(en), 32'h0);
      goto(24); chk("a_restart", 32'(en), 32'h1); chk("a_restart_busy", 32'(busy), 32'h1);

      // synchronous reset from ON
      do_reset(); pwr_req = 1'b1;
      goto(37); chk("r_on", 32'(pg_ok), 32'h1);
      goto(40); rst = 1'b1;
      goto(41); chk("r_en", 32'(en), 32'h0); chk("r_pgok", 32'(pg_ok), 32'h0);
      chk("r_fault", 32'(fault), 32'h0); chk("r_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      goto(42); chk("r_restart", 32'(en), 32'h1); chk("r_restart_busy", 32'(busy), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
